spi_frame_ctrl: RTL and testbench
=================================

Name: spi_frame_ctrl

Overview:
Command sequencer between the SPI byte receiver and the BNN inference core. It parses the received byte stream (rx_data/rx_valid) into commands and writes image payload bytes into the image buffer. It starts inference, then latches the classification result. It drives a registered status byte that is preloaded as the SPI transmit word, so the host reads status on every transaction.

Parameters:
IMG_BYTES, 113, payload bytes per image (900-bit 30x30 frame, last byte zero-padded)
ADDR_W, 7, image buffer address width; must satisfy 2^ADDR_W >= IMG_BYTES
TIMEOUT_CYCLES, 1000000, max clk cycles between payload bytes before LOAD aborts (20 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  async active-low reset
rx_data  input  8  received byte from SPI receiver
rx_valid  input  1  one-cycle pulse, rx_data valid
img_we  output  1  image buffer write enable
img_addr  output  ADDR_W  image buffer write address
img_wdata  output  8  image buffer write data
infer_start  output  1  one-cycle pulse, begin inference
infer_done  input  1  one-cycle pulse from inference core
infer_result  input  4  class index, valid with infer_done
tx_data  output  8  status byte for SPI transmit preload
busy  output  1  high in LOAD or BUSY state
err  output  1  sticky error flag

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. All outputs are registered.
- Reset values: state IDLE, img_we=0, img_addr=0, img_wdata=0, infer_start=0, busy=0, err=0, result=0, result_valid=0, img_loaded=0, tx_data=8'h00.
- Reset mid-operation aborts any LOAD or BUSY with no further writes or pulses.
- Commands in IDLE (only rx_data sampled when rx_valid=1):
  - 0x00 NOP: no action.
  - 0xA1 LOAD: addr counter=0, img_loaded=0, result_valid=0, timeout counter=0, go to LOAD.
  - 0xA2 START: if img_loaded=1, pulse infer_start on the next cycle and go to BUSY. Otherwise set err and stay IDLE.
  - 0xA3 CLR_ERR: err=0.
  - Any other value: set err.
- LOAD state:
  - Each rx_valid writes the byte: img_we=1 for exactly one cycle, in the cycle after rx_valid, with img_addr=counter and img_wdata=rx_data. The counter then increments.
  - The write of address IMG_BYTES-1 sets img_loaded=1 and returns to IDLE in the same cycle as that img_we. No command decoding happens in LOAD.
  - Timeout counter clears on every rx_valid and otherwise increments. When it reaches TIMEOUT_CYCLES-1: go to IDLE, set err, img_loaded=0.
  - If rx_valid coincides with the timeout terminal count, the byte wins: it is written and the counter clears.
- BUSY state:
  - infer_done=1: next cycle latch result=infer_result, result_valid=1, go to IDLE.
  - rx_valid with 0x00 is ignored; any other byte sets err and is discarded, with no state change.
  - If infer_done and rx_valid occur in the same cycle, both effects apply.
  - infer_done outside BUSY is ignored.
- busy = (state==LOAD || state==BUSY), registered with the state.
- tx_data is updated every cycle from the next-state values, so it reflects the post-event status one cycle after the event: {busy, result_valid, err, img_loaded, result[3:0]}.
- img_addr wraps never: the LOAD exit at IMG_BYTES-1 guarantees the address stays below IMG_BYTES.
- Back-to-back rx_valid on consecutive cycles must be accepted with no byte loss, i.e. one byte per cycle throughput.

Test Plan:
- Reset, then NOP -> tx_data=8'h00, busy=0, no img_we.
- LOAD + 113 bytes 0x00..0x70 -> 113 img_we pulses, addr 0..112, data equals addr. After the last write: busy=0, tx_data=8'h10.
- START, then hold 5 cycles, then infer_done with result 4'h7 -> one infer_start pulse, tx_data=8'h80 while BUSY, then 8'h47.
- START after reset (no image loaded) -> no infer_start, err=1, tx_data=8'h20. Then CLR_ERR -> tx_data=8'h00.
- LOAD + 10 bytes, then silence with TIMEOUT_CYCLES=16 -> state IDLE after 16 idle cycles, err=1, img_loaded=0. A following START is rejected.
- Byte 0x55 during BUSY -> err=1, result unaffected. Assert rst_n=0 mid-LOAD -> all outputs return to reset values immediately, no further img_we.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: command sequencer between the SPI byte receiver and the
// BNN inference core. Decodes host commands, streams image payload bytes
// into the image buffer, starts inference, latches the class result and
// keeps a registered status byte ready as the SPI transmit preload.
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   rx_data, rx_valid    received byte and its one-cycle valid pulse
//   img_we/addr/wdata    image buffer write port
//   infer_start          one-cycle pulse to begin inference
//   infer_done/result    completion pulse and class index from the core
//   tx_data              {busy, result_valid, err, img_loaded, result[3:0]}
//   busy                 high while loading or inferring
//   err                  sticky error flag, cleared by CLR_ERR
module spi_frame_ctrl #(
  parameter int unsigned IMG_BYTES      = 113,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              infer_start,
  input  logic              infer_done,
  input  logic [3:0]        infer_result,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned TOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_LOAD  = 8'hA1;
  localparam logic [7:0] CMD_START = 8'hA2;
  localparam logic [7:0] CMD_CLR   = 8'hA3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic [3:0]          result_q, result_d;
  logic                rv_q, rv_d;
  logic                loaded_q, loaded_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [TOUT_W-1:0]   tout_q, tout_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [7:0]          tx_q, tx_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      result_q <= 4'h0;
      rv_q     <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      tout_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= 8'h00;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    result_d = result_q;
    rv_d     = rv_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    tout_d   = tout_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    start_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_NOP: ;
            CMD_LOAD: begin
              cnt_d    = '0;
              tout_d   = '0;
              loaded_d = 1'b0;
              rv_d     = 1'b0;
              state_d  = S_LOAD;
            end
            CMD_START: begin
              if (loaded_q) begin
                // Inference consumes the image; a new LOAD is needed per run
                start_d  = 1'b1;
                loaded_d = 1'b0;
                state_d  = S_BUSY;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_CLR: err_d = 1'b0;
            default: err_d = 1'b1;
          endcase
        end
      end

      S_LOAD: begin
        // An arriving byte takes priority over the timeout terminal count
        if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = rx_data;
          cnt_d   = cnt_q + ADDR_W'(1);
          tout_d  = '0;
          if (cnt_q == LAST_ADDR) begin
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (tout_q == TOUT_LAST) begin
          err_d    = 1'b1;
          loaded_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end

      S_BUSY: begin
        if (infer_done) begin
          result_d = infer_result;
          rv_d     = 1'b1;
          state_d  = S_IDLE;
        end
        if (rx_valid && (rx_data != CMD_NOP)) begin
          err_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_BUSY);
    tx_d   = {busy_d, rv_d, err_d, loaded_d, result_d};
  end

  assign img_we      = we_q;
  assign img_addr    = waddr_q;
  assign img_wdata   = wdata_q;
  assign infer_start = start_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign tx_data     = tx_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: command vectors from a table plus
// hand-written load, timeout and reset sequences. Short timeout (16).
module tb_spi_frame_ctrl;

  localparam int unsigned IMG_BYTES = 113;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned TOUT      = 16;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_wdata;
  logic              infer_start;
  logic              infer_done;
  logic [3:0]        infer_result;
  logic [7:0]        tx_data;
  logic              busy;
  logic              err;

  spi_frame_ctrl #(
    .IMG_BYTES      (IMG_BYTES),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .img_we       (img_we),
    .img_addr     (img_addr),
    .img_wdata    (img_wdata),
    .infer_start  (infer_start),
    .infer_done   (infer_done),
    .infer_result (infer_result),
    .tx_data      (tx_data),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         seg;
    logic       rv;
    logic [7:0] data;
    logic       done;
    logic [3:0] res;
    logic [7:0] exp_tx;
    logic       exp_busy;
    logic       exp_start;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   we_cnt = 0;
  int   start_cnt = 0;
  int   load_base = 0;
  int   base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int seg, input logic rv, input logic [7:0] data,
                     input logic done, input logic [3:0] res,
                     input logic [7:0] etx, input logic ebusy, input logic estart);
    vec_t v;
    v.seg = seg; v.rv = rv; v.data = data; v.done = done; v.res = res;
    v.exp_tx = etx; v.exp_busy = ebusy; v.exp_start = estart;
    tbl.push_back(v);
  endtask

  task automatic run_seg(input int s);
    foreach (tbl[i]) begin
      if (tbl[i].seg == s) begin
        rx_valid     = tbl[i].rv;
        rx_data      = tbl[i].data;
        infer_done   = tbl[i].done;
        infer_result = tbl[i].res;
        step();
        chk($sformatf("seg%0d.v%0d tx_data", s, i), 32'(tx_data), 32'(tbl[i].exp_tx));
        chk($sformatf("seg%0d.v%0d busy", s, i), 32'(busy), 32'(tbl[i].exp_busy));
        chk($sformatf("seg%0d.v%0d infer_start", s, i), 32'(infer_start), 32'(tbl[i].exp_start));
      end
    end
    rx_valid   = 1'b0;
    infer_done = 1'b0;
  endtask

  // Sends LOAD then n bytes whose value equals their index
  task automatic load_img(input int n, input logic [7:0] tx_cmd, input logic full,
                          input logic [7:0] tx_end);
    load_base = we_cnt;
    rx_valid = 1'b1;
    rx_data  = 8'hA1;
    step();
    chk("load_cmd tx_data", 32'(tx_data), 32'(tx_cmd));
    chk("load_cmd busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      step();
      if (full && i == n - 1) begin
        chk("load_last busy", 32'(busy), 32'd0);
        chk("load_last tx_data", 32'(tx_data), 32'(tx_end));
      end else if (!busy) begin
        chk("load_mid busy", 32'(busy), 32'd1);
      end
    end
    rx_valid = 1'b0;
    if (full) begin
      step();
      chk("load write count", 32'(we_cnt - load_base), 32'(n));
    end
  endtask

  // Write-port monitor: every write must land at the next address with data==address
  always @(negedge clk) begin
    if (rst_n && img_we) begin
      chk("img_addr", 32'(img_addr), 32'(we_cnt - load_base));
      chk("img_wdata", 32'(img_wdata), 32'(8'(we_cnt - load_base)));
      we_cnt++;
    end
    if (rst_n && infer_start) start_cnt++;
  end

  initial begin
    // seg0: idle command decode
    add(0, 1, 8'h00, 0, 4'h0, 8'h00, 0, 0);
    add(0, 1, 8'hA2, 0, 4'h0, 8'h20, 0, 0);
    add(0, 1, 8'hA3, 0, 4'h0, 8'h00, 0, 0);
    add(0, 1, 8'h5A, 0, 4'h0, 8'h20, 0, 0);
    add(0, 1, 8'hA3, 0, 4'h0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 4'h9, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 0, 4'h0, 8'h20, 0, 0);
    add(0, 1, 8'hA3, 0, 4'h0, 8'h00, 0, 0);
    // seg1: start, hold five cycles, done with class 7
    add(1, 1, 8'hA2, 0, 4'h0, 8'h80, 1, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 8'h00, 0, 4'h0, 8'h80, 1, 0);
    add(1, 0, 8'h00, 1, 4'h7, 8'h47, 0, 0);
    add(1, 1, 8'hA2, 0, 4'h0, 8'h67, 0, 0);
    add(1, 1, 8'hA3, 0, 4'h0, 8'h47, 0, 0);
    // seg2: bytes during BUSY, done coinciding with a bad byte
    add(2, 1, 8'hA2, 0, 4'h0, 8'h87, 1, 1);
    add(2, 1, 8'h55, 0, 4'h0, 8'hA7, 1, 0);
    add(2, 1, 8'h00, 0, 4'h0, 8'hA7, 1, 0);
    add(2, 1, 8'h66, 1, 4'h3, 8'h63, 0, 0);
    add(2, 1, 8'hA3, 0, 4'h0, 8'h43, 0, 0);
    // seg3: start after a timed-out load is rejected
    add(3, 1, 8'hA2, 0, 4'h0, 8'h23, 0, 0);
    add(3, 1, 8'hA3, 0, 4'h0, 8'h03, 0, 0);

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    infer_done = 1'b0; infer_result = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("reset tx_data", 32'(tx_data), 32'h00);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset img_we", 32'(img_we), 32'd0);
    chk("reset img_addr", 32'(img_addr), 32'd0);

    run_seg(0);
    chk("idle no writes", 32'(we_cnt), 32'd0);
    load_img(IMG_BYTES, 8'h80, 1'b1, 8'h10);
    run_seg(1);
    load_img(IMG_BYTES, 8'h87, 1'b1, 8'h17);
    run_seg(2);

    // Timeout: 10 bytes, a byte landing exactly on the terminal count, then silence
    load_img(10, 8'h83, 1'b0, 8'h00);
    repeat (15) step();
    chk("tout pre-terminal busy", 32'(busy), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'd10;
    step();
    rx_valid = 1'b0;
    chk("tout byte-wins img_we", 32'(img_we), 32'd1);
    chk("tout byte-wins img_addr", 32'(img_addr), 32'd10);
    chk("tout byte-wins busy", 32'(busy), 32'd1);
    repeat (15) step();
    chk("tout 15 idle busy", 32'(busy), 32'd1);
    step();
    chk("tout expire busy", 32'(busy), 32'd0);
    chk("tout expire err", 32'(err), 32'd1);
    chk("tout expire tx_data", 32'(tx_data), 32'h23);
    step();
    chk("tout write count", 32'(we_cnt - load_base), 32'd11);
    run_seg(3);
    step();
    chk("infer_start count", 32'(start_cnt), 32'd2);

    // Reset mid-LOAD with bytes still arriving
    load_img(5, 8'h83, 1'b0, 8'h00);
    step();
    chk("pre-reset write count", 32'(we_cnt - load_base), 32'd5);
    base = we_cnt;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    rst_n    = 1'b0;
    #1;
    chk("async reset img_we", 32'(img_we), 32'd0);
    chk("async reset img_addr", 32'(img_addr), 32'd0);
    chk("async reset img_wdata", 32'(img_wdata), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset tx_data", 32'(tx_data), 32'h00);
    chk("async reset err", 32'(err), 32'd0);
    chk("async reset infer_start", 32'(infer_start), 32'd0);
    step();
    step();
    chk("in reset img_we", 32'(img_we), 32'd0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    step();
    chk("post-reset write count", 32'(we_cnt), 32'(base));
    chk("post-reset tx_data", 32'(tx_data), 32'h00);
    chk("post-reset busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
